button_event_counter: RTL
=========================

// Module: button_event_counter
// PURPOSE
//  Parametrised debounced up/down counter driven by board pushbuttons and slide switches.
//  - Each qualified edge changes the count by exactly one; a held input has no further effect.
//  - Two independent counters:
//    - KEY pair: active-low pushbuttons.
//    - SW pair: active-high switches.
//  - Sits between raw board I/O and the 7-seg/LED display logic.
// PARAMETERS
//  CNT_W      7      width of count_KEY / count_SW
//  DEB_CNT    50000  consecutive stable cycles required to accept an input change (>=2)
//  DEB_W      16     width of each debounce counter; must hold DEB_CNT
//  SAT        0      0 = wrap modulo 2^CNT_W, 1 = saturate at 0 and 2^CNT_W-1
//  REP_DELAY  25000000  hold cycles before first auto-repeat (used only with macro)
//  REP_PERIOD 5000000   cycles between subsequent auto-repeats (used only with macro)
// PORTS
//  clk        in   1      system clock; all logic rising-edge
//  rst        in   1      synchronous, active-low reset
//  KEY        in   2      raw pushbuttons, active-low; [0]=inc, [1]=dec
//  SW         in   2      raw switches, active-high; [0]=inc, [1]=dec
//  count_KEY  out  CNT_W  pushbutton counter
//  count_SW   out  CNT_W  switch counter
//  evt        out  4      1-cycle event pulses {SW[1],SW[0],KEY[1],KEY[0]}
//  db_state   out  4      debounced active levels, same order (1 = pressed/on)
// BEHAVIOUR
//  Reset (rst==0 at clk edge) clears all state:
//  - count_KEY = 0, count_SW = 0, evt = 0, db_state = 0.
//  - Debounce counters = 0.
//  - Synchronisers load the inactive level (KEY=1, SW=0).
//  Input path, per input, fully independent:
//  - 2-flop synchroniser.
//  - Debounce counter:
//    - Increments while the synced level differs from db_state.
//    - Clears when the synced level equals db_state.
//    - On reaching DEB_CNT, db_state flips and the counter clears.
//  - Glitch shorter than DEB_CNT cycles: no db_state change, no event.
//  Event generation:
//  - evt[i] = 1 for exactly one cycle, in the cycle after db_state[i] goes 0->1.
//  - Release (1->0) produces no event.
//  Counter update:
//  - Happens in the same cycle evt is high.
//  - Latency: count changes DEB_CNT+3 cycles after a clean raw edge.
//  Arithmetic, per counter:
//  - inc event only: +1.
//  - dec event only: -1.
//  - inc and dec events in the same cycle: no change, both evt bits still pulse.
//  - KEY and SW counters update independently in the same cycle; no priority between them.
//  Boundaries:
//  - SAT=0: 2^CNT_W-1 +1 -> 0; 0 -1 -> 2^CNT_W-1.
//  - SAT=1: max +1 stays max; 0 -1 stays 0; evt still pulses.
//  Reset mid-operation:
//  - Partial debounce counts are discarded; no event is generated by the reset itself.
//  - An input held active across reset release is treated as a new press and counts once,
//    DEB_CNT+3 cycles after release.
// CONFIGURATION
//  Macro BUTTON_EVENT_COUNTER_REPEAT_EN:
//  - Defined: each KEY channel has a hold timer.
//    - Timer runs while db_state[k]=1.
//    - After REP_DELAY cycles held, emits a repeat event; then one every REP_PERIOD cycles.
//    - Repeat events pulse evt[k] and count exactly like a press.
//    - Timer clears on release and on reset.
//    - SW channels never repeat.
//  - Undefined: no hold timers are synthesised; REP_DELAY and REP_PERIOD are ignored.
//    - A held key counts exactly once.
// TESTING (bench uses DEB_CNT=4, CNT_W=4, REP_DELAY=20, REP_PERIOD=5)
//  1. Reset, then KEY[0]=0 held 30 cycles.
//     -> evt[0] high for 1 cycle, count_KEY 0->1 exactly 7 cycles after the edge.
//     -> Without macro: no further change.
//  2. KEY[1] pulse of 3 cycles low (bounce).
//     -> no evt, count_KEY unchanged, db_state[1] stays 0.
//  3. SAT=0: 16 SW[0] rising edges from 0 -> count_SW wraps to 0 on the 16th.
//     SAT=1: 0 then SW[1] edge -> count_SW stays 0, evt[3] still pulses.
//  4. KEY[0] and KEY[1] pressed on the same cycle.
//     -> evt[1:0]=2'b11 for 1 cycle, count_KEY unchanged.
//     SW[0] edge in the same cycle -> count_SW +1.
//  5. rst=0 for 1 cycle while KEY[0] held and mid-debounce.
//     -> all outputs 0; after release, count_KEY=1 exactly 7 cycles later.
//  6. With REPEAT_EN: KEY[0] held 40 cycles after acceptance.
//     -> count_KEY steps at +0, +20, +25, +30, +35.
//     Release -> no more steps.

Source files
------------

// File: rtl/button_event_counter.sv
// button_event_counter
//   Debounced up/down event counter for raw board pushbuttons (KEY, active-low)
//   and slide switches (SW, active-high). Each input has a two-flop
//   synchroniser and a stability counter. A debounced press gives a one-cycle
//   evt pulse, and that pulse steps the matching counter.
//   Optional feature macro: BUTTON_EVENT_COUNTER_REPEAT_EN adds auto-repeat
//   hold timers on the two KEY channels.
module button_event_counter #(
    parameter int CNT_W      = 7,
    parameter int DEB_CNT    = 50000,
    parameter int DEB_W      = 16,
    parameter int SAT        = 0,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       KEY,
    input  logic [1:0]       SW,
    output logic [CNT_W-1:0] count_KEY,
    output logic [CNT_W-1:0] count_SW,
    output logic [3:0]       evt,
    output logic [3:0]       db_state
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject parameter sets the debounce and repeat logic cannot honour
    generate
        if (DEB_CNT < 2 || DEB_CNT > (2 ** DEB_W) - 1 || REP_PERIOD < 1 || REP_DELAY < REP_PERIOD) begin : g_bad_params
            $error("button_event_counter: illegal DEB_CNT/DEB_W/REP_DELAY/REP_PERIOD combination");
        end
    endgenerate

    logic [1:0]       key_s1, key_s2;
    logic [1:0]       sw_s1, sw_s2;
    logic [3:0]       act;
    logic [DEB_W-1:0] deb_cnt [4];
    logic [3:0]       db_prev;
    logic [3:0]       rise;
    logic [3:0]       rep;
    logic [3:0]       trig;

    // Synchronised levels in "1 = active" form, ordered {SW1, SW0, KEY1, KEY0}
    assign act = {sw_s2, ~key_s2};

    // Two-flop synchronisers; reset loads the inactive level of each input
    always_ff @(posedge clk) begin
        // NOTE: every state register uses <= so that all flops sample the same pre-edge values.
        if (!rst) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            sw_s1  <= 2'b00;
            sw_s2  <= 2'b00;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    // Debounce: count cycles of disagreement and accept the new level after DEB_CNT cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: this small counter array is cleared explicitly because partial counts must not survive a reset.
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
            db_state <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (act[i] != db_state[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        db_state[i] <= act[i];
                        deb_cnt[i]  <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef BUTTON_EVENT_COUNTER_REPEAT_EN
    localparam int REP_W = $clog2(REP_DELAY + 1);
    localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REP_DELAY);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REP_DELAY - REP_PERIOD + 1);
    localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);

    logic [REP_W-1:0] hold_t [2];

    // KEY hold timers: fire at REP_DELAY, then rewind so they fire again every REP_PERIOD
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) hold_t[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!db_state[k])
                    hold_t[k] <= '0;
                else if (hold_t[k] == REP_FIRE)
                    hold_t[k] <= REP_RELOAD;
                else
                    hold_t[k] <= hold_t[k] + REP_ONE;
            end
        end
    end

    assign rep = {2'b00,
                  db_state[1] & (hold_t[1] == REP_FIRE),
                  db_state[0] & (hold_t[0] == REP_FIRE)};
`else
    assign rep = 4'b0000;
`endif

    assign rise = db_state & ~db_prev;
    assign trig = rise | rep;

    // One up/down step; simultaneous inc and dec cancel out
    function automatic logic [CNT_W-1:0] step(input logic [CNT_W-1:0] cur,
                                              input logic inc, input logic dec);
        logic [CNT_W-1:0] nxt;
        // NOTE: defaulting nxt first keeps every path assigned, so no latch-like hold is implied.
        nxt = cur;
        if (inc && !dec) begin
            if (!(SAT != 0 && cur == '1)) nxt = cur + CNT_ONE;
        end else if (dec && !inc) begin
            if (!(SAT != 0 && cur == '0)) nxt = cur - CNT_ONE;
        end
        return nxt;
    endfunction

    // Event pulses and both counters update on the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            db_prev   <= '0;
            evt       <= '0;
            count_KEY <= '0;
            count_SW  <= '0;
        end else begin
            db_prev   <= db_state;
            evt       <= trig;
            count_KEY <= step(count_KEY, trig[0], trig[1]);
            count_SW  <= step(count_SW, trig[2], trig[3]);
        end
    end

endmodule
